// File: rtl/win_pkg.sv
// Shared constants and state encoding for the sine-window path.
// The window multiplier takes its frame length from this package as well.
package win_pkg;

    localparam int WIN_DW        = 12;
    localparam int WIN_AW        = 12;
    localparam int WIN_FRAME_LEN = 128;
    localparam int WIN_GAP_LEN   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        GAP
    } win_state_t;

    // Counter width that never collapses to zero bits for tiny lengths.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win_idx_cnt.sv
// Modulo-FRAME_LEN window index counter with enable, sync clear and a
// terminal-count flag. Its value becomes the window address of each sample.
module win_idx_cnt
    import win_pkg::*;
#(
    parameter int FRAME_LEN = WIN_FRAME_LEN,
    parameter int CW        = clog2_min1(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(FRAME_LEN - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order in which processes execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/win_frame_seq.sv
// Frame sequencer: cuts a free-running sample stream into FRAME_LEN frames,
// tags each sample with its window address and emits frame start/clear markers.
module win_frame_seq
    import win_pkg::*;
#(
    parameter int DW        = WIN_DW,
    parameter int AW        = WIN_AW,
    parameter int FRAME_LEN = WIN_FRAME_LEN,
    parameter int GAP_LEN   = WIN_GAP_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          start,
    input  logic          cont,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [AW-1:0] addr,
    output logic          starto,
    output logic          rsto,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    localparam int CW = clog2_min1(FRAME_LEN);
    localparam int GW = clog2_min1(GAP_LEN);

    win_state_t    state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          pending, pending_nxt;
    logic [CW-1:0] cnt;
    logic          tc;
    logic          take;

    assign busy = (state != IDLE);
    assign take = (state == RUN) && din_valid;

    win_idx_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_idx_cnt (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .clr (state == ARM),
        .cnt (cnt),
        .tc  (tc)
    );

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        gap_nxt     = gap_cnt;
        pending_nxt = pending | (busy & start);
        unique case (state)
            IDLE: begin
                if (start || cont) state_nxt = ARM;
            end
            ARM: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (take && tc) begin
                    gap_nxt = '0;
                    if (GAP_LEN == 0) state_nxt = (cont || pending_nxt) ? ARM : IDLE;
                    else              state_nxt = GAP;
                end
            end
            GAP: begin
                if (int'(gap_cnt) >= GAP_LEN - 1) begin
                    gap_nxt   = '0;
                    state_nxt = (cont || pending_nxt) ? ARM : IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
        endcase
        // A request that arrives on the re-arm clock is served by that frame.
        if (state_nxt == ARM) pending_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            addr       <= '0;
            starto     <= 1'b0;
            frame_done <= 1'b0;
            rsto       <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            pending    <= pending_nxt;
            if (busy && start) overrun <= 1'b1;
            rsto       <= (state == ARM);
            dout_valid <= take;
            starto     <= take && (cnt == '0);
            frame_done <= take && tc;
            // Address holds across invalid clocks in a frame, reads 0 elsewhere.
            if (take) begin
                dout <= din;
                addr <= AW'(cnt);
            end else if (state != RUN) begin
                addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_win_frame_seq.sv
// Scoreboard bench for win_frame_seq: expected samples are queued as they are
// driven and popped as dout_valid beats come out.
module tb_win_frame_seq;

    localparam int DW = 12;
    localparam int AW = 12;
    localparam int FL = 128;
    localparam int GL = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          s;
        logic          f;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          start;
    logic          cont;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW-1:0] addr;
    logic          starto;
    logic          rsto;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    exp_t          exp_q[$];
    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    int            nvalid = 0;
    int            done_cyc = 0;
    bit            have_done = 1'b0;
    bit            chk_spacing = 1'b0;
    logic [DW-1:0] ramp = '0;

    always #5 clk = ~clk;

    win_frame_seq #(
        .DW        (DW),
        .AW        (AW),
        .FRAME_LEN (FL),
        .GAP_LEN   (GL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .start      (start),
        .cont       (cont),
        .dout       (dout),
        .dout_valid (dout_valid),
        .addr       (addr),
        .starto     (starto),
        .rsto       (rsto),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Advance one clock and score any output beat against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (dout_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_valid: got dout=%0h addr=%0d, required no beat (cycle %0d)",
                         dout, addr, cyc);
            end else begin
                e = exp_q.pop_front();
                nvalid++;
                if ({dout, addr, starto, frame_done} !== {e.d, e.a, e.s, e.f})
                    $display("FAIL beat: got dout=%0h addr=%0d starto=%0b done=%0b, required dout=%0h addr=%0d starto=%0b done=%0b",
                             dout, addr, starto, frame_done, e.d, e.a, e.s, e.f);
                else
                    passed++;
                if (starto === 1'b1 && chk_spacing && have_done) begin
                    total++;
                    if (cyc - done_cyc !== GL + 2)
                        $display("FAIL frame_spacing: got %0d clks, required %0d", cyc - done_cyc, GL + 2);
                    else
                        passed++;
                end
                if (frame_done === 1'b1) begin
                    done_cyc  = cyc;
                    have_done = 1'b1;
                end
            end
        end
    endtask

    // Request a frame (pulse start or raise cont) and step through ARM.
    task automatic arm_frame(input bit use_cont);
        if (use_cont) cont = 1'b1;
        else          start = 1'b1;
        din_valid = 1'b1;
        din       = DW'($urandom);
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || rsto !== 1'b0)
            $display("FAIL arm_state: got busy=%0b rsto=%0b, required busy=1 rsto=0", busy, rsto);
        else
            passed++;
        din = DW'($urandom);
        tick();
        total++;
        if (rsto !== 1'b1)
            $display("FAIL rsto_pulse: got %0b, required 1", rsto);
        else
            passed++;
    endtask

    // Drive n samples of a frame starting in its first RUN clock.
    task automatic send_frame(input int n, input bit gappy, input int st_a, input int st_b,
                              input int cont_off);
        logic [DW-1:0] sd;
        for (int i = 0; i < n; i++) begin
            din       = ramp;
            sd        = ramp;
            ramp      = ramp + 1'b1;
            din_valid = 1'b1;
            start     = (i == st_a) || (i == st_b);
            if (i == cont_off) cont = 1'b0;
            exp_q.push_back('{d: sd, a: AW'(i), s: (i == 0), f: (i == FL - 1)});
            tick();
            start = 1'b0;
            if (i == 0) begin
                total++;
                if (rsto !== 1'b0)
                    $display("FAIL rsto_one_clk: got %0b, required 0", rsto);
                else
                    passed++;
            end
            if (gappy && i < n - 1) begin
                din_valid = 1'b0;
                din       = DW'($urandom);
                tick();
                total++;
                if (dout_valid !== 1'b0 || addr !== AW'(i) || dout !== sd)
                    $display("FAIL gap_hold: got valid=%0b addr=%0d dout=%0h, required valid=0 addr=%0d dout=%0h",
                             dout_valid, addr, dout, i, sd);
                else
                    passed++;
            end
        end
        din_valid = 1'b1;
        din       = DW'($urandom);
    endtask

    // Walk the inter-frame gap; optionally expect a re-arm afterwards.
    task automatic gap_ticks(input bit rearm);
        int bad = 0;
        for (int k = 1; k <= GL; k++) begin
            din_valid = 1'b1;
            din       = DW'($urandom);
            tick();
            if (k < GL && busy !== 1'b1) bad++;
            if (rsto !== 1'b0) bad++;
        end
        total++;
        if (bad != 0 || busy !== rearm)
            $display("FAIL gap_len: got %0d bad gap clks busy=%0b, required 0 bad busy=%0b", bad, busy, rearm);
        else
            passed++;
        if (rearm) begin
            din = DW'($urandom);
            tick();
            total++;
            if (rsto !== 1'b1 || busy !== 1'b1)
                $display("FAIL rearm: got rsto=%0b busy=%0b, required rsto=1 busy=1", rsto, busy);
            else
                passed++;
        end
    endtask

    task automatic check_drained(input int want_valid);
        total++;
        if (exp_q.size() != 0 || nvalid != want_valid)
            $display("FAIL drained: got %0d beats (%0d queued), required %0d beats (0 queued)",
                     nvalid, exp_q.size(), want_valid);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = '0; din_valid = 1'b0; start = 1'b0; cont = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({dout, dout_valid, addr, starto, rsto, busy, frame_done, overrun} !== '0)
            $display("FAIL reset_values: got dout=%0h v=%0b addr=%0d st=%0b rsto=%0b busy=%0b done=%0b ovr=%0b, required all 0",
                     dout, dout_valid, addr, starto, rsto, busy, frame_done, overrun);
        else
            passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_isolation();
        int bad_v = 0, bad_a = 0, bad_r = 0;
        din_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            din = DW'($urandom);
            tick();
            if (dout_valid !== 1'b0 || busy !== 1'b0) bad_v++;
            if (addr !== '0) bad_a++;
            if (rsto !== 1'b0) bad_r++;
        end
        total++;
        if (bad_v != 0) $display("FAIL idle_valid: got %0d active clks, required 0", bad_v); else passed++;
        total++;
        if (bad_a != 0) $display("FAIL idle_addr: got %0d nonzero clks, required 0", bad_a); else passed++;
        total++;
        if (bad_r != 0) $display("FAIL idle_rsto: got %0d pulses, required 0", bad_r); else passed++;
    endtask

    task automatic test_single_frame();
        nvalid = 0; have_done = 1'b0; chk_spacing = 1'b0;
        arm_frame(1'b0);
        send_frame(FL, 1'b0, -1, -1, -1);
        gap_ticks(1'b0);
        check_drained(FL);
    endtask

    task automatic test_gappy();
        nvalid = 0;
        arm_frame(1'b0);
        send_frame(FL, 1'b1, -1, -1, -1);
        gap_ticks(1'b0);
        check_drained(FL);
    endtask

    task automatic test_continuous();
        nvalid = 0; have_done = 1'b0; chk_spacing = 1'b1;
        arm_frame(1'b1);
        send_frame(FL, 1'b0, -1, -1, -1);
        gap_ticks(1'b1);
        send_frame(FL, 1'b0, -1, -1, -1);
        gap_ticks(1'b1);
        send_frame(FL, 1'b0, -1, -1, 10);
        gap_ticks(1'b0);
        repeat (20) tick();
        check_drained(3 * FL);
        chk_spacing = 1'b0;
    endtask

    task automatic test_overrun();
        nvalid = 0; have_done = 1'b0; chk_spacing = 1'b1;
        total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %0b, required 0", overrun); else passed++;
        arm_frame(1'b0);
        send_frame(FL, 1'b0, 50, 60, -1);
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %0b, required 1", overrun); else passed++;
        gap_ticks(1'b1);
        // Start coinciding with the last sample also counts as a busy request.
        send_frame(FL, 1'b0, FL - 1, -1, -1);
        gap_ticks(1'b1);
        send_frame(FL, 1'b0, -1, -1, -1);
        gap_ticks(1'b0);
        repeat (20) tick();
        check_drained(3 * FL);
        total++;
        if (overrun !== 1'b1 || busy !== 1'b0)
            $display("FAIL overrun_sticky: got ovr=%0b busy=%0b, required ovr=1 busy=0", overrun, busy);
        else
            passed++;
        chk_spacing = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        nvalid = 0;
        arm_frame(1'b0);
        send_frame(71, 1'b0, -1, -1, -1);
        rst = 1'b1;
        #1;
        total++;
        if ({dout, dout_valid, addr, starto, rsto, busy, frame_done, overrun} !== '0)
            $display("FAIL mid_reset: got dout=%0h v=%0b addr=%0d st=%0b rsto=%0b busy=%0b done=%0b ovr=%0b, required all 0",
                     dout, dout_valid, addr, starto, rsto, busy, frame_done, overrun);
        else
            passed++;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        nvalid = 0;
        arm_frame(1'b0);
        send_frame(FL, 1'b0, -1, -1, -1);
        gap_ticks(1'b0);
        check_drained(FL);
    endtask

    initial begin
        test_reset();
        test_idle_isolation();
        test_single_frame();
        test_gappy();
        test_continuous();
        test_overrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
